// File: rtl/spi_rom_fetch_if.sv
// Core-side fetch handshake plus flash pad signals for spi_rom_fetch.
//   req_i/addr_i     : fetch request and 13-bit program word address
//   busy_o/ready_o   : busy from acceptance to completion; ready is a 1-clk pulse
//   instr_o          : 16-bit instruction word, held until the next ready_o
//   rom_cs_n_o, rom_sclk_o, rom_io_o, rom_io_oe_o, rom_io_i : quad-SPI pads
// slave  : the fetch unit
// master : the core / pad ring side
interface spi_rom_fetch_if;
  logic        req_i;
  logic [12:0] addr_i;
  logic        busy_o;
  logic        ready_o;
  logic [15:0] instr_o;
  logic        rom_cs_n_o;
  logic        rom_sclk_o;
  logic [3:0]  rom_io_o;
  logic [3:0]  rom_io_oe_o;
  logic [3:0]  rom_io_i;

  modport slave (
    input  req_i, addr_i, rom_io_i,
    output busy_o, ready_o, instr_o, rom_cs_n_o, rom_sclk_o, rom_io_o, rom_io_oe_o
  );

  modport master (
    output req_i, addr_i, rom_io_i,
    input  busy_o, ready_o, instr_o, rom_cs_n_o, rom_sclk_o, rom_io_o, rom_io_oe_o
  );
endinterface

// File: rtl/spi_rom_fetch.sv
// Instruction fetch front end: turns a program word address into a Fast Read
// Quad Output (0x6B) transaction on a serial flash and returns one 16-bit
// big-endian instruction. Sequential fetches continue the open transaction.
//   clk   : system clock, sclk runs at clk/2 (low phase, then high phase)
//   rst_n : asynchronous active-low reset
//   bus   : spi_rom_fetch_if.slave (core handshake + flash pads)
module spi_rom_fetch #(
  parameter logic [23:0] BASE_ADDR    = 24'h000000,
  parameter int          DUMMY_CYCLES = 8,
  parameter int          CS_IDLE      = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_rom_fetch_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CS_GAP, CMD, ADDR, DUMMY, DATA, STREAM} state_e;

  localparam int         CNT_W    = 16;
  localparam logic [7:0] CMD_FRQO = 8'h6B;

  state_e           state_q, state_d;
  logic             ph_q, ph_d;          // 0 = sclk low phase, 1 = high phase
  logic [CNT_W-1:0] cnt_q, cnt_d;        // remaining bits / sclk / gap clocks, minus one
  logic [31:0]      sh_q, sh_d;          // command byte followed by address, MSB first
  logic [11:0]      dat_q, dat_d;        // first three nibbles of the word in flight
  logic [15:0]      instr_q, instr_d;
  logic [12:0]      addr_q, addr_d;      // word being fetched
  logic [12:0]      last_q, last_d;      // word the open stream points past
  logic             ready_q, ready_d;

  logic [23:0]      byte_addr;
  logic             seq_hit;
  logic             serial_st;

  assign byte_addr = BASE_ADDR + {10'd0, bus.addr_i, 1'b0};
  // Continuation only when the next word follows directly; 8191 -> 0 would
  // need the flash to wrap the byte address, so it is treated as a redirect.
  assign seq_hit   = (last_q != 13'h1FFF) && (bus.addr_i == last_q + 13'd1);
  assign serial_st = (state_q == CMD) || (state_q == ADDR) ||
                     (state_q == DUMMY) || (state_q == DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= 1'b0;
      cnt_q   <= '0;
      sh_q    <= '0;
      dat_q   <= '0;
      instr_q <= '0;
      addr_q  <= '0;
      last_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dat_q   <= dat_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    dat_d   = dat_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    last_d  = last_q;
    ready_d = 1'b0;

    // Every serial state advances one sclk period per two clocks; work
    // happens on the clock that ends the high phase.
    if (serial_st) ph_d = ~ph_q;

    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          addr_d  = bus.addr_i;
          sh_d    = {CMD_FRQO, byte_addr};
          cnt_d   = CNT_W'(7);
          ph_d    = 1'b0;
          state_d = CMD;
        end
      end

      CS_GAP: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(7);
          ph_d    = 1'b0;
          state_d = CMD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      CMD: begin
        if (ph_q) begin
          sh_d = {sh_q[30:0], 1'b0};
          if (cnt_q == '0) begin
            cnt_d   = CNT_W'(23);
            state_d = ADDR;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      ADDR: begin
        if (ph_q) begin
          sh_d = {sh_q[30:0], 1'b0};
          if (cnt_q == '0) begin
            if (DUMMY_CYCLES == 0) begin
              cnt_d   = CNT_W'(3);
              state_d = DATA;
            end else begin
              cnt_d   = CNT_W'(DUMMY_CYCLES - 1);
              state_d = DUMMY;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      DUMMY: begin
        if (ph_q) begin
          if (cnt_q == '0) begin
            cnt_d   = CNT_W'(3);
            state_d = DATA;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      DATA: begin
        if (ph_q) begin
          dat_d = {dat_q[7:0], bus.rom_io_i};
          if (cnt_q == '0) begin
            instr_d = {dat_q, bus.rom_io_i};
            ready_d = 1'b1;
            last_d  = addr_q;
            state_d = STREAM;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      STREAM: begin
        if (bus.req_i) begin
          addr_d = bus.addr_i;
          ph_d   = 1'b0;
          if (seq_hit) begin
            cnt_d   = CNT_W'(3);
            state_d = DATA;
          end else begin
            sh_d    = {CMD_FRQO, byte_addr};
            cnt_d   = CNT_W'(CS_IDLE - 1);
            state_d = CS_GAP;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Pad outputs decode straight from registered state so an asynchronous
  // reset returns them to idle levels immediately.
  assign bus.rom_cs_n_o  = (state_q == IDLE) || (state_q == CS_GAP);
  assign bus.rom_sclk_o  = serial_st && ph_q;
  assign bus.rom_io_o    = ((state_q == CMD) || (state_q == ADDR)) ? {2'b11, 1'b0, sh_q[31]} : 4'b0000;
  assign bus.rom_io_oe_o = ((state_q == CMD) || (state_q == ADDR)) ? 4'b1101 : 4'b0000;
  assign bus.busy_o      = (state_q != IDLE) && (state_q != STREAM);
  assign bus.ready_o     = ready_q;
  assign bus.instr_o     = instr_q;

endmodule

// File: tb/tb_spi_rom_fetch.sv
// Bench for spi_rom_fetch: two instances (BASE_ADDR 0 and 0x100000) share
// the same request stream, each attached to its own behavioural quad-SPI
// flash model. Latencies are counted in clocks after the accepting edge, so
// "ready_o in cycle T+89" is 88 edges after the edge that sampled req_i.
module tb_spi_rom_fetch;
  localparam int DUMMY = 8;
  localparam int CSI   = 2;
  localparam int BITS  = 2 * (8 + 24 + DUMMY + 4);
  localparam int K_COLD = 0, K_CONT = 1, K_REDIR = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req   = 1'b0;
  logic [12:0] addr  = '0;
  int checks   = 0;
  int failures = 0;

  bit          sv   = 1'b0;   // model: a stream is open
  logic [12:0] last = '0;     // model: last word delivered

  always #5 clk = ~clk;

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    case (a)
      24'h000000: return 8'hC0;
      24'h000001: return 8'h59;
      24'h000002: return 8'h12;
      24'h000003: return 8'h34;
      24'h00000A: return 8'hAB;
      24'h00000B: return 8'hCD;
      default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [15:0] exp_instr(input logic [23:0] base, input logic [12:0] a);
    logic [23:0] b;
    b = base + 24'(2 * int'(a));
    return {fbyte(b), fbyte(b + 24'd1)};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam logic [23:0] BASE = (g == 0) ? 24'h000000 : 24'h100000;
    spi_rom_fetch_if bus ();
    logic [3:0]  io_drv = '0;
    logic [7:0]  cmd = '0;
    logic [23:0] adr = '0;
    int nrise = 0, cmd_cnt = 0, cs_rise = 0, gap = 0, gap_run = 0;
    bit proto_err = 1'b0;

    assign bus.req_i    = req;
    assign bus.addr_i   = addr;
    assign bus.rom_io_i = io_drv;

    spi_rom_fetch #(.BASE_ADDR(BASE), .DUMMY_CYCLES(DUMMY), .CS_IDLE(CSI)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // Flash: sample io0 on sclk rise for command+address, then after the
    // dummy clocks shift out nibbles on each sclk fall, streaming forward.
    always @(negedge bus.rom_cs_n_o or posedge bus.rom_sclk_o) begin
      if (!bus.rom_sclk_o) nrise = 0;
      else if (!bus.rom_cs_n_o) begin
        if (nrise < 32) begin
          if (bus.rom_io_oe_o !== 4'b1101 || bus.rom_io_o[3:2] !== 2'b11) proto_err = 1'b1;
          if (nrise < 8) cmd = {cmd[6:0], bus.rom_io_o[0]};
          else           adr = {adr[22:0], bus.rom_io_o[0]};
          if (nrise == 31) cmd_cnt++;
        end else if (bus.rom_io_oe_o !== 4'b0000) proto_err = 1'b1;
        nrise++;
      end
    end

    always @(negedge bus.rom_sclk_o) begin
      int j;
      logic [7:0] b;
      if (!bus.rom_cs_n_o && nrise >= 32 + DUMMY) begin
        j = nrise - (32 + DUMMY);
        b = fbyte(adr + 24'(j / 2));
        io_drv = j[0] ? b[3:0] : b[7:4];
      end
    end

    always @(posedge clk) begin
      if (bus.rom_cs_n_o) gap_run++;
      else if (gap_run != 0) begin
        gap = gap_run;
        gap_run = 0;
      end
    end

    always @(posedge bus.rom_cs_n_o) cs_rise++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [12:0] a, input int kind, input bit poke);
    int c0, r0, n, exp_lat;
    bit busy_ok;
    exp_lat = (kind == K_CONT) ? 8 : ((kind == K_REDIR) ? CSI + BITS : BITS);
    c0 = g_dut[0].cmd_cnt;
    r0 = g_dut[0].cs_rise;
    @(negedge clk); req = 1'b1; addr = a;
    @(posedge clk); #1; req = 1'b0;
    chk("cs_after_accept", g_dut[0].bus.rom_cs_n_o, kind == K_REDIR);
    n = 0;
    busy_ok = 1'b1;
    while (g_dut[0].bus.ready_o !== 1'b1 && n < 400) begin
      if (g_dut[0].bus.busy_o !== 1'b1 || g_dut[1].bus.busy_o !== 1'b1) busy_ok = 1'b0;
      if (poke) begin
        req  = (n == 20);
        addr = (n == 20) ? 13'd7 : a;
      end
      @(posedge clk); #1; n++;
    end
    req = 1'b0;
    chk("latency", n, exp_lat);
    chk("busy_while_fetching", busy_ok, 1);
    chk("ready_both", g_dut[1].bus.ready_o, 1);
    chk("busy_low_at_ready", {g_dut[0].bus.busy_o, g_dut[1].bus.busy_o}, 0);
    chk("instr_base0", g_dut[0].bus.instr_o, exp_instr(24'h000000, a));
    chk("instr_base1", g_dut[1].bus.instr_o, exp_instr(24'h100000, a));
    if (kind == K_CONT) begin
      chk("cont_no_cmd", g_dut[0].cmd_cnt, c0);
      chk("cont_cs_held", g_dut[0].cs_rise, r0);
    end else begin
      chk("cmd_issued", g_dut[0].cmd_cnt, c0 + 1);
      chk("cmd_byte", g_dut[0].cmd, 8'h6B);
      chk("addr_base0", g_dut[0].adr, 24'(2 * int'(a)));
      chk("addr_base1", g_dut[1].adr, 24'h100000 + 24'(2 * int'(a)));
      if (kind == K_REDIR) chk("cs_gap", g_dut[0].gap, CSI);
    end
    @(posedge clk); #1;
    chk("ready_pulse", g_dut[0].bus.ready_o, 0);
    chk("instr_hold", g_dut[0].bus.instr_o, exp_instr(24'h000000, a));
    sv   = 1'b1;
    last = a;
  endtask

  initial begin
    int rdy;
    #3 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_cs", g_dut[0].bus.rom_cs_n_o, 1);
    chk("rst_sclk", g_dut[0].bus.rom_sclk_o, 0);
    chk("rst_oe_io", {g_dut[0].bus.rom_io_oe_o, g_dut[0].bus.rom_io_o}, 0);
    chk("rst_busy_ready", {g_dut[0].bus.busy_o, g_dut[0].bus.ready_o}, 0);
    chk("rst_instr", g_dut[0].bus.instr_o, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fetch(13'd0,    K_COLD,  1'b0);   // C059
    fetch(13'd1,    K_CONT,  1'b0);   // 1234 from the open stream
    fetch(13'd5,    K_REDIR, 1'b0);   // ABCD, new command at 0x00000A
    fetch(13'd8191, K_REDIR, 1'b0);   // 0x003FFE / 0x103FFE
    fetch(13'd0,    K_REDIR, 1'b0);   // 8191 -> 0 is not sequential

    // Reset in the middle of the address phase.
    @(negedge clk); req = 1'b1; addr = 13'd3;
    @(posedge clk); #1; req = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("in_addr_phase_oe", g_dut[0].bus.rom_io_oe_o, 4'b1101);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_cs", {g_dut[0].bus.rom_cs_n_o, g_dut[1].bus.rom_cs_n_o}, 2'b11);
    chk("midrst_oe", g_dut[0].bus.rom_io_oe_o, 0);
    chk("midrst_busy", g_dut[0].bus.busy_o, 0);
    chk("midrst_sclk_ready", {g_dut[0].bus.rom_sclk_o, g_dut[0].bus.ready_o}, 0);
    chk("midrst_instr", g_dut[0].bus.instr_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sv = 1'b0;
    fetch(13'd1, K_COLD, 1'b0);       // cold despite 1 following 0 earlier

    // Request for word 7 while busy must be dropped.
    fetch(13'd10, K_REDIR, 1'b1);
    rdy = 0;
    repeat (120) begin
      @(posedge clk); #1;
      if (g_dut[0].bus.ready_o === 1'b1 || g_dut[0].bus.busy_o === 1'b1) rdy++;
    end
    chk("ignored_req_no_activity", rdy, 0);

    for (int i = 0; i < 14; i++) begin
      logic [12:0] a;
      int kind;
      a = ($urandom_range(0, 1) == 1) ? 13'(int'(last) + 1) : 13'($urandom_range(0, 8191));
      if (!sv) kind = K_COLD;
      else if (int'(a) == int'(last) + 1) kind = K_CONT;
      else kind = K_REDIR;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      fetch(a, kind, 1'b0);
    end

    chk("proto_base0", g_dut[0].proto_err, 0);
    chk("proto_base1", g_dut[1].proto_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_rom_fetch.md
# spi_rom_fetch

Instruction-fetch front end for the 8x305 core: turns a 13-bit program-counter request into a Fast Read Quad Output (0x6B) transaction on the external W25Q128-class flash and returns a 16-bit instruction word. It sits between the core's program-memory port and the ROM pads (ROM_cs, ROM_sclk, romlines[3:0]). Sequential fetches stream from an open transaction without re-issuing command and address.

## Interface
- BASE_ADDR, 24'h000000, flash byte offset of program word 0
- DUMMY_CYCLES, 8, sclk periods between address and data (0x6B requires 8)
- CS_IDLE, 2, clk cycles CS# held high between transactions (≥ 1)
- clk  in  1  system clock; sclk = clk/2
- rst_n  in  1  asynchronous active-low reset
- req_i  in  1  fetch request; sampled only while busy_o=0
- addr_i  in  13  program word address, captured with req_i
- busy_o  out  1  high from acceptance until ready_o
- ready_o  out  1  one-cycle pulse, instr_o valid
- instr_o  out  16  fetched instruction; holds until next ready_o
- rom_cs_n_o  out  1  flash chip select, active low
- rom_sclk_o  out  1  flash serial clock, idles low (mode 0)
- rom_io_o  out  4  pad output data (io0=DI, io1=DO, io2=WP#, io3=HOLD#)
- rom_io_oe_o  out  4  pad output enables, 1 = drive
- rom_io_i  in  4  pad input data

## Operation
- States: IDLE, CS_GAP, CMD, ADDR, DUMMY, DATA, STREAM.
- Byte address = BASE_ADDR + {addr_i, 1'b0}, 24-bit, wraps modulo 2^24.
- Instruction is big-endian: first nibble on io[3:0] → instr_o[15:12], last → [3:0].
- Acceptance in IDLE (CS# high): go to CMD directly.
- Acceptance in STREAM (CS# low): if addr_i == last_addr + 1 (13-bit compare, no wrap; 8191→0 is not sequential), go to DATA (continuation). Otherwise raise CS#, go CS_GAP for CS_IDLE clk, then CMD.
- CMD: 8 bits 0x6B on io0, MSB first. ADDR: 24 bits on io0, MSB first. During CMD/ADDR rom_io_oe_o = 4'b1101, io2 = io3 = 1, io1 input.
- DUMMY: DUMMY_CYCLES sclk, rom_io_oe_o = 0. DATA: 4 sclk, rom_io_oe_o = 0, one nibble per sclk.
- After DATA: pulse ready_o, update instr_o and last_addr, enter STREAM with CS# still low and sclk low.
- STREAM holds CS# low indefinitely while idle; no timeout.
- req_i while busy_o=1 is ignored; the core holds its request until ready_o.

## Timing
- Each sclk period = 2 clk: low phase then high phase. Outputs change only at start of low phase; rom_io_i sampled on the clk edge ending the high phase.
- Cold fetch (from IDLE): req_i sampled at edge T; CS# low and first CMD bit on io0 at T+1; ready_o high in cycle T + 1 + 2*(8+24+DUMMY_CYCLES+4) = T+89 with defaults.
- Continuation: ready_o at T+9.
- Redirect from STREAM: ready_o at T + CS_IDLE + 89 (T+91 default).
- busy_o rises at T+1, falls in the ready_o cycle; new request may be sampled at the edge ending the ready_o cycle.
- Reset values: rom_cs_n_o=1, rom_sclk_o=0, rom_io_oe_o=0, rom_io_o=0, busy_o=0, ready_o=0, instr_o=0, state IDLE, stream-valid cleared.
- rst_n low mid-transaction: all outputs to reset values immediately (asynchronous); no ready_o; first fetch after release is cold.

## Test plan
- Flash bytes 0x000000..01 = C0 59; reset, request addr 0 → rom_io_o shows 0x6B then 0x000000 on io0, ready_o at T+89, instr_o = 16'hC059.
- Follow with addr 1 (bytes 02..03 = 12 34) → no new command, CS# stays low, ready_o at T+9, instr_o = 16'h1234.
- Then request addr 5 (bytes 0A..0B = AB CD) → CS# high exactly 2 clk, full command with address 0x00000A, ready_o at T+91, instr_o = 16'hABCD.
- BASE_ADDR = 24'h100000, fetch addr 8191 then addr 0 → addresses 0x103FFE then 0x100000; second is a redirect, not continuation.
- Assert rst_n low during ADDR phase → CS# high, oe=0, busy_o=0 same cycle; after release, fetch addr 1 issues full command, instr_o = 16'h1234.
- req_i pulsed with addr 7 while busy_o=1 → ignored; only the original fetch completes, single ready_o.
